hamming_enc_stream: RTL

- Streaming Hamming(7,4) encoder that sits directly upstream of the single-error-correcting Hamming decoder.
- Accepts bytes on a valid/ready input, splits each byte into two nibbles (low nibble first) and emits one registered 7-bit codeword per output handshake.
- Codeword bit layout is positional: index i carries Hamming position i+1.
  - Parity bits sit at code[0], code[1], code[3].
  - Data bits sit at code[2], code[4], code[5], code[6].
- Keeps a running count of emitted codewords for link statistics.

---
 rtl/hamming_enc_stream.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hamming_enc_stream.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_enc_stream
//  Description : Byte-stream Hamming(7,4) encoder, low nibble first, with a
//                wrapping count of codewords accepted downstream.
//                Optional error injection enabled by HAMMING_ERR_INJ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_enc_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [6:0]       out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cw_count
`ifdef HAMMING_ERR_INJ_EN
    ,
    input  logic             inj_valid,
    input  logic [2:0]       inj_pos,
    output logic             inj_pending
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2
    } state_t;

    state_t           state_q;
    logic [6:0]       code_q;
    logic [6:0]       code_d;
    logic [3:0]       hi_nib_q;
    logic [CNT_W-1:0] cw_q;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load;
    logic [3:0]       w_load_nib;
    logic [6:0]       w_flip;

    // Index i of the codeword carries Hamming position i+1.
    function automatic logic [6:0] f_enc(input logic [3:0] d);
        logic [6:0] c;
        c    = 7'd0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    assign out_valid  = (state_q != S_EMPTY);
    assign in_ready   = (state_q == S_EMPTY) | ((state_q == S_HI) & out_ready);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign out_code   = code_q;
    assign cw_count   = cw_q;

    always_comb begin
        w_load     = 1'b0;
        w_load_nib = in_data[3:0];
        case (state_q)
            S_EMPTY: w_load = w_in_fire;
            S_LO: begin
                w_load     = w_out_fire;
                w_load_nib = hi_nib_q;
            end
            S_HI:    w_load = w_out_fire & w_in_fire;
            default: w_load = 1'b0;
        endcase
    end

`ifdef HAMMING_ERR_INJ_EN
    logic       inj_pend_q;
    logic [2:0] inj_pos_q;
    logic       w_inj_arm;
    logic       w_inj_pend;
    logic [2:0] w_inj_pos;

    // A request arriving with a load applies to that same load.
    assign w_inj_arm  = inj_valid & (inj_pos != 3'd0);
    assign w_inj_pend = inj_pend_q | w_inj_arm;
    assign w_inj_pos  = w_inj_arm ? inj_pos : inj_pos_q;
    assign w_flip     = w_inj_pend ? (7'd1 << (w_inj_pos - 3'd1)) : 7'd0;
    assign inj_pending = inj_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_pend_q <= 1'b0;
            inj_pos_q  <= 3'd0;
        end else begin
            inj_pos_q  <= w_inj_pos;
            inj_pend_q <= w_inj_pend & ~w_load;
        end
    end
`else
    assign w_flip = 7'd0;
`endif

    assign code_d = f_enc(w_load_nib) ^ w_flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            code_q   <= 7'd0;
            hi_nib_q <= 4'd0;
            cw_q     <= '0;
        end else begin
            if (w_out_fire) begin
                cw_q <= cw_q + 1'b1;
            end
            if (w_load) begin
                code_q <= code_d;
            end
            case (state_q)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        hi_nib_q <= in_data[7:4];
                        state_q  <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_out_fire) begin
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (w_out_fire & w_in_fire) begin
                        hi_nib_q <= in_data[7:4];
                        state_q  <= S_LO;
                    end else if (w_out_fire) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire
